// File: rtl/pixel_frame_feeder.sv
// Buffers a raw RGB source stream in a small FWFT FIFO and feeds it, tagged with
// raster coordinates, to image_processor once the compensation matrix is valid.
module pixel_frame_feeder #(
    parameter int unsigned IMAGE_WIDTH  = 768,
    parameter int unsigned IMAGE_HEIGHT = 512,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  matrix_valid,
    input  logic [23:0]           src_rgb,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [23:0]           out_rgb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_x,
    output logic [15:0]           out_y,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [31:0]         TOTAL  = 32'(IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam logic [15:0]         X_LAST = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0]         Y_LAST = 16'(IMAGE_HEIGHT - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH  = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_MATRIX, STREAM, DONE} state_t;

    state_t                state_q;
    logic [23:0]           mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [31:0]           in_count_q;
    logic [15:0]           x_q, y_q;
    logic                  done_q, busy_q;
    logic                  push, pop, eol, eof;

    // src_ready ignores a same-cycle pop, so a full FIFO never accepts.
    always_comb begin
        src_ready = ((state_q == WAIT_MATRIX) || (state_q == STREAM))
                    && (level_q < DEPTH) && (in_count_q < TOTAL);
        out_valid = (state_q == STREAM) && (level_q != '0) && matrix_valid;
        push      = src_valid && src_ready;
        pop       = out_valid && out_ready;
        eol       = out_valid && (x_q == X_LAST);
        eof       = eol && (y_q == Y_LAST);
        level_d   = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    assign out_rgb    = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign out_x      = x_q;
    assign out_y      = y_q;
    assign out_eol    = eol;
    assign out_eof    = eof;
    assign fifo_level = level_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= src_rgb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_count_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            level_q <= level_d;
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                in_count_q <= in_count_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q    <= WAIT_MATRIX;
                        busy_q     <= 1'b1;
                        in_count_q <= '0;
                        x_q        <= '0;
                        y_q        <= '0;
                    end
                end
                WAIT_MATRIX: begin
                    if (matrix_valid) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (pop && eof) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_feeder.sv
// Self-checking bench for pixel_frame_feeder: a per-cycle vector table for the
// first frame, a pixel scoreboard, and directed stall / full / reset sequences.
module tb_pixel_frame_feeder;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start, matrix_valid, src_valid, out_ready;
    logic [23:0]   src_rgb;
    logic          src_ready, out_valid, out_eol, out_eof, busy, frame_done;
    logic [23:0]   out_rgb;
    logic [15:0]   out_x, out_y;
    logic [AW:0]   fifo_level;

    int            checks = 0;
    int            errors = 0;
    logic [23:0]   exp_q[$];
    logic [23:0]   next_pix;
    int            mx, my, n_out;
    logic          eof_prev;

    typedef struct {
        logic fs, sv, mv, ordy;
        logic e_sr;
        int   e_lvl;
        logic e_ov, e_busy;
    } vec_t;
    vec_t tbl[18];

    pixel_frame_feeder #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .FIFO_DEPTH  (D),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .matrix_valid(matrix_valid),
        .src_rgb     (src_rgb),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .out_rgb     (out_rgb),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .fifo_level  (fifo_level),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One cycle: settle inputs, score transfers that will happen at the next posedge.
    task automatic tick();
        logic adv, ev;
        logic [23:0] e;
        adv = 1'b0;
        ev  = 1'b0;
        #1;
        chk("frame_done", frame_done, eof_prev);
        if (!out_valid) begin
            chk("eol_unqualified", out_eol, 0);
            chk("eof_unqualified", out_eof, 0);
        end
        if (src_valid && src_ready) begin
            exp_q.push_back(src_rgb);
            adv = 1'b1;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_extra actual=%06h required=none", out_rgb);
            end else begin
                e = exp_q.pop_front();
                chk("out_rgb", out_rgb, e);
            end
            chk("out_x", out_x, mx);
            chk("out_y", out_y, my);
            chk("out_eol", out_eol, (mx == W - 1));
            chk("out_eof", out_eof, (mx == W - 1) && (my == H - 1));
            ev = (mx == W - 1) && (my == H - 1);
            n_out++;
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        eof_prev = ev;
        @(negedge clk);
        if (adv) begin
            next_pix++;
            src_rgb = next_pix;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_out_rgb", out_rgb, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_eol", out_eol, 0);
        chk("rst_out_eof", out_eof, 0);
        exp_q.delete();
        eof_prev = 1'b0;
        mx = 0;
        my = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic begin_frame(input logic [23:0] base, input logic mv, input logic ordy);
        next_pix     = base;
        src_rgb      = base;
        src_valid    = 1'b1;
        matrix_valid = mv;
        out_ready    = ordy;
        frame_start  = 1'b1;
        mx = 0;
        my = 0;
        n_out = 0;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (frame_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_frame_done required=frame_done within %0d cycles", budget);
        end else begin
            tick();
            chk("busy_after_done", busy, 0);
            chk("frame_pixel_count", n_out, W * H);
            chk("scoreboard_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        rst_n        = 1'b1;
        frame_start  = 1'b0;
        matrix_valid = 1'b0;
        src_valid    = 1'b0;
        out_ready    = 1'b0;
        src_rgb      = '0;
        next_pix     = '0;
        eof_prev     = 1'b0;
        mx = 0;
        my = 0;
        n_out = 0;
        #2;
        apply_reset();

        // Idle after reset: nothing accepted, everything quiet.
        next_pix  = 24'h000001;
        src_rgb   = next_pix;
        src_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_src_ready", src_ready, 0);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_busy", busy, 0);
            chk("idle_fifo_level", fifo_level, 0);
            chk("idle_out_rgb", out_rgb, 0);
            tick();
        end

        // Prefill with matrix_valid low, then stream the whole frame.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        for (int r = 0; r < 18; r++) begin
            frame_start  = tbl[r].fs;
            src_valid    = tbl[r].sv;
            matrix_valid = tbl[r].mv;
            out_ready    = tbl[r].ordy;
            if (tbl[r].fs) begin
                mx = 0;
                my = 0;
                n_out = 0;
            end
            #1;
            chk($sformatf("vec%0d_src_ready", r), src_ready, tbl[r].e_sr);
            chk($sformatf("vec%0d_fifo_level", r), fifo_level, tbl[r].e_lvl);
            chk($sformatf("vec%0d_out_valid", r), out_valid, tbl[r].e_ov);
            chk($sformatf("vec%0d_busy", r), busy, tbl[r].e_busy);
            tick();
        end
        chk("vec_frame_pixels", n_out, W * H);
        chk("vec_scoreboard_empty", exp_q.size(), 0);

        // Output stall via out_ready, then via matrix_valid.
        begin_frame(24'h000100, 1'b1, 1'b1);
        for (int i = 0; i < 20 && n_out < 2; i++) tick();
        chk("stall_reach_2", n_out, 2);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_out_valid", out_valid, 1);
            if (exp_q.size() > 0) chk("stall_out_rgb", out_rgb, exp_q[0]);
            chk("stall_out_x", out_x, mx);
            chk("stall_out_y", out_y, my);
            tick();
        end
        out_ready    = 1'b1;
        matrix_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mstall_out_valid", out_valid, 0);
            if (exp_q.size() > 0) chk("mstall_out_rgb", out_rgb, exp_q[0]);
            chk("mstall_out_x", out_x, mx);
            chk("mstall_out_y", out_y, my);
            tick();
        end
        matrix_valid = 1'b1;
        run_until_done(40);

        // Full FIFO: a pop does not open a slot in the same cycle.
        begin_frame(24'h000300, 1'b0, 1'b0);
        for (int i = 0; i < 20 && fifo_level != 4; i++) tick();
        chk("full_prefill_level", fifo_level, 4);
        matrix_valid = 1'b1;
        tick();
        out_ready = 1'b1;
        #1;
        chk("full_src_ready", src_ready, 0);
        chk("full_level", fifo_level, 4);
        chk("full_out_valid", out_valid, 1);
        tick();
        #1;
        chk("full_after_pop_level", fifo_level, 3);
        out_ready = 1'b0;
        #1;
        chk("refill_src_ready", src_ready, 1);
        tick();
        #1;
        chk("refill_level", fifo_level, 4);
        out_ready = 1'b1;
        run_until_done(40);

        // Reset mid-frame, then a fresh frame must start clean.
        begin_frame(24'h000200, 1'b1, 1'b1);
        for (int i = 0; i < 20 && n_out < 3; i++) tick();
        chk("abort_reach_3", n_out, 3);
        apply_reset();
        src_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        begin_frame(24'h0000A0, 1'b1, 1'b1);
        tick();
        #1;
        chk("restart_out_valid", out_valid, 1);
        chk("restart_first_rgb", out_rgb, 24'h0000A0);
        chk("restart_first_x", out_x, 0);
        chk("restart_first_y", out_y, 0);
        run_until_done(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
